mem_req_ctrl: RTL and testbench

- Request front-end that sits directly upstream of the single-port RAM (`memory`) and drives its addr/wr_en/rd_en/wdata inputs.
- Accepts read/write requests over a valid/ready interface and buffers them in a small FIFO.
- Issues one RAM operation at a time, captures the RAM's one-cycle-latency rdata, and returns read data over a valid/ready response interface with backpressure.

---
 rtl/mem_req_ctrl.sv | 143 ++++++++++++++
 tb/tb_mem_req_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_req_ctrl
//  Brief    : Request FIFO and sequencer in front of a one-cycle-latency
//             single-port RAM. Returns read data over a valid/ready interface.
//  Revision : 1.0
// ============================================================================
module mem_req_ctrl #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic                                req_write,
  input  logic [ADDR_WIDTH-1:0]               req_addr,
  input  logic [DATA_WIDTH-1:0]               req_wdata,
  output logic                                rsp_valid,
  input  logic                                rsp_ready,
  output logic [DATA_WIDTH-1:0]               rsp_rdata,
  output logic [ADDR_WIDTH-1:0]               mem_addr,
  output logic                                mem_wr_en,
  output logic                                mem_rd_en,
  output logic [DATA_WIDTH-1:0]               mem_wdata,
  input  logic [DATA_WIDTH-1:0]               mem_rdata,
  output logic                                busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = ADDR_WIDTH + DATA_WIDTH + 1;

  localparam logic [CW-1:0] c_FULL = CW'(FIFO_DEPTH);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_ISSUE   = 2'd1;
  localparam logic [1:0] c_RD_WAIT = 2'd2;
  localparam logic [1:0] c_RSP     = 2'd3;

  // Entry layout: {write flag, address, write data}
  logic [EW-1:0]         r_fifo [FIFO_DEPTH];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;
  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic                  r_mem_wr_en;
  logic                  r_mem_rd_en;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;

  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic [EW-1:0]         w_head;

  assign w_full    = (r_count == c_FULL);
  assign req_ready = reset && !w_full;
  assign w_push    = req_valid && req_ready;
  assign w_pop     = (r_state == c_IDLE) && (r_count != '0);
  assign w_head    = r_fifo[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wptr] <= {req_write, req_addr, req_wdata};
    end
  end

  // Pointers wrap naturally since the depth is a power of two
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= c_IDLE;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wr_en <= 1'b0;
      r_mem_rd_en <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_pop) begin
            r_mem_addr <= w_head[DATA_WIDTH +: ADDR_WIDTH];
            if (w_head[EW-1]) begin
              r_mem_wdata <= w_head[DATA_WIDTH-1:0];
              r_mem_wr_en <= 1'b1;
            end else begin
              r_mem_rd_en <= 1'b1;
            end
            r_state <= c_ISSUE;
          end
        end
        c_ISSUE: begin
          r_mem_wr_en <= 1'b0;
          r_mem_rd_en <= 1'b0;
          r_state     <= r_mem_rd_en ? c_RD_WAIT : c_IDLE;
        end
        c_RD_WAIT: begin
          r_rsp_rdata <= mem_rdata;
          r_rsp_valid <= 1'b1;
          r_state     <= c_RSP;
        end
        default: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= c_IDLE;
          end
        end
      endcase
    end
  end

  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_wr_en  = r_mem_wr_en;
  assign mem_rd_en  = r_mem_rd_en;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_rdata  = r_rsp_rdata;
  assign fifo_count = r_count;
  assign busy       = (r_state != c_IDLE) || (r_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_mem_req_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_req_ctrl
//  Brief    : Randomized bench for mem_req_ctrl against a timed transaction
//             model, with a behavioural one-cycle-latency RAM attached.
//  Revision : 1.0
// ============================================================================
module tb_mem_req_ctrl;

  localparam int AW    = 2;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_wr_en;
  logic          mem_rd_en;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          busy;
  logic [CW-1:0] fifo_count;

  mem_req_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: powers up to all-ones, never reset, rdata one cycle after rd_en
  logic [DW-1:0] ram [1<<AW] = '{default: 8'hFF};
  always @(posedge clk) begin
    if (mem_wr_en) ram[mem_addr] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= ram[mem_addr];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level reference: queued requests plus issue/response timing
  typedef struct packed {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } req_t;

  req_t          m_q[$];
  logic [DW-1:0] m_ram [1<<AW] = '{default: 8'hFF};
  int            m_cyc    = 0;
  int            m_free   = 0;
  int            m_rsp_at = -1;
  bit            m_wr, m_rd, m_rsp_valid, m_rd_out, m_pushed;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata, m_pend;

  task automatic model_step();
    int   sz;
    req_t r;
    m_cyc++;
    m_pushed = 1'b0;
    if (!reset) begin
      m_q.delete();
      m_wr = 0; m_rd = 0; m_rsp_valid = 0; m_rd_out = 0;
      m_addr = '0; m_wdata = '0; m_rdata = '0;
      m_rsp_at = -1;
      m_free = m_cyc + 1;
      return;
    end
    sz = m_q.size();
    if (m_rsp_valid && rsp_ready) begin
      m_rsp_valid = 0;
      m_rd_out = 0;
      m_free = m_cyc + 1;
    end
    m_wr = 0;
    m_rd = 0;
    if (m_rd_out && m_rsp_at == m_cyc) begin
      m_rsp_valid = 1;
      m_rdata = m_pend;
    end
    if (!m_rd_out && m_cyc >= m_free && sz != 0) begin
      r = m_q.pop_front();
      m_addr = r.a;
      if (r.w) begin
        m_wr = 1;
        m_wdata = r.d;
        m_ram[r.a] = r.d;
        m_free = m_cyc + 2;
      end else begin
        m_rd = 1;
        m_rd_out = 1;
        m_pend = m_ram[r.a];
        m_rsp_at = m_cyc + 2;
      end
    end
    if (req_valid && sz < DEPTH) begin
      m_q.push_back('{w: req_write, a: req_addr, d: req_wdata});
      m_pushed = 1'b1;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check("req_ready",  req_ready,  reset && (m_q.size() < DEPTH));
    check("fifo_count", fifo_count, m_q.size());
    check("busy",       busy,       (m_q.size() != 0) || m_wr || m_rd || m_rd_out);
    check("mem_wr_en",  mem_wr_en,  m_wr);
    check("mem_rd_en",  mem_rd_en,  m_rd);
    check("mem_addr",   mem_addr,   m_addr);
    check("mem_wdata",  mem_wdata,  m_wdata);
    check("rsp_valid",  rsp_valid,  m_rsp_valid);
    check("rsp_rdata",  rsp_rdata,  m_rdata);
  endtask

  task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!m_pushed && n < 100);
    if (!m_pushed) check("send_timeout", 0, 1);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((m_q.size() != 0 || m_wr || m_rd || m_rd_out) && n < 200) begin
      cyc();
      n++;
    end
    if (n >= 200) check("idle_timeout", 0, 1);
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    repeat (3) cyc();
    reset = 1'b1;

    // never-written address, then write/read-back of 0xA5
    send(1'b0, 2'd1, 8'h00);
    wait_idle();
    send(1'b1, 2'd2, 8'hA5);
    send(1'b0, 2'd2, 8'h00);
    wait_idle();

    // response stalled while the FIFO fills, then drain and read back
    rsp_ready = 1'b0;
    send(1'b0, 2'd2, 8'h00);
    for (int i = 0; i < 4; i++) send(1'b1, AW'(i), 8'h10 + DW'(i));
    req_valid = 1'b1; req_write = 1'b0; req_addr = 2'd0;
    repeat (5) cyc();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(1'b0, AW'(i), 8'h00);
    wait_idle();

    // reset while the read is waiting on RAM data, with more requests queued
    send(1'b0, 2'd3, 8'h00);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 2'd1; req_wdata = 8'h5C;
    cyc();
    cyc();
    req_valid = 1'b0;
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    repeat (8) cyc();

    // randomized traffic with occasional backpressure and resets
    for (int i = 0; i < 1500; i++) begin
      req_valid = ($urandom_range(0, 2) != 0);
      req_write = $urandom_range(0, 1);
      req_addr  = AW'($urandom);
      req_wdata = DW'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 299) != 0);
      cyc();
    end
    req_valid = 1'b0;
    reset = 1'b1;
    rsp_ready = 1'b1;
    wait_idle();
    repeat (3) cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
